nco_i2s_dac_tx: RTL and testbench

- Downstream stage of the 14-bit sin/cos NCO in the Dac design.
- Takes each valid NCO sample pair into a one-deep holding register and left-aligns it to the codec slot width.
- Serialises the pair onto an I2S-format stream (BCLK, DACLRCK, DACDAT) for the DE1 audio codec: sin on the left channel, cos on the right.
- Issues one sample request per frame, which can drive the NCO clock enable, and flags underrun and overrun.

---
 rtl/nco_i2s_dac_tx.sv | 196 +++++++++++++++++++
 tb/tb_nco_i2s_dac_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_i2s_dac_tx.sv
// nco_i2s_dac_tx
// Serialises 14-bit sin/cos NCO sample pairs onto an I2S stream for the DE1
// audio codec: sin in the left slot, cos in the right slot, MSB first, with
// data lagging DACLRCK by one BCLK. A one-deep holding register decouples the
// NCO from the frame timing. One sample request is issued per frame, and
// underrun/overrun pulses flag starved or overwritten samples.
module nco_i2s_dac_tx #(
    parameter int MPR       = 14,
    parameter int SW        = 16,
    parameter int BCLK_HALF = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [MPR-1:0] fsin_i,
    input  logic [MPR-1:0] fcos_i,
    input  logic           in_valid,
    input  logic           mute,
    output logic           sample_req,
    output logic           bclk,
    output logic           daclrck,
    output logic           dacdat,
    output logic           underrun,
    output logic           overrun
);

    // Derived sizes. The divider keeps at least one bit so BCLK_HALF=1 still
    // elaborates; in that case the counter simply sits at zero.
    localparam int DIV_W   = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int SLOT_W  = $clog2(2 * SW);
    localparam int FRAME_W = 2 * SW;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_HALF - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE    = DIV_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(2 * SW - 1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SW);
    localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);

    // Left-align an MPR-bit two's complement sample into an SW-bit slot word.
    // The sample occupies the top bits, so the sign bit stays the slot MSB and
    // the low (SW-MPR) bits are zero-filled.
    function automatic logic signed [SW-1:0] left_align(
        input logic signed [MPR-1:0] x
    );
        logic signed [SW-1:0] r;
        r = '0;
        r[SW-1 -: MPR] = x;
        return r;
    endfunction

    // Bit-clock generation
    logic [DIV_W-1:0]  div_q,  div_d;
    logic              bclk_q, bclk_d;
    logic              tick;        // divider terminal count: bclk toggles
    logic              fall;        // this toggle is a falling edge of bclk
    logic              wrap;        // falling edge that ends slot 2*SW-1

    // Slot tracking
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              lrck_q, lrck_d;

    // Serial datapath
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic                 dat_q,   dat_d;
    logic signed [SW-1:0] frame_l_q, frame_l_d;
    logic signed [SW-1:0] frame_r_q, frame_r_d;

    // Holding register
    logic signed [MPR-1:0] hold_sin_q, hold_sin_d;
    logic signed [MPR-1:0] hold_cos_q, hold_cos_d;
    logic                  full_q,     full_d;

    // Status pulses
    logic req_q,   req_d;
    logic under_q, under_d;
    logic over_q,  over_d;

    assign tick = (div_q == DIV_LAST);
    assign fall = tick & bclk_q;
    assign wrap = fall & (slot_q == SLOT_LAST);

    // Divider counts 0..BCLK_HALF-1 and flips bclk on its terminal count.
    always_comb begin
        div_d  = div_q + DIV_ONE;
        bclk_d = bclk_q;
        if (tick) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
        end
    end

    // Slot counter advances on each falling bclk toggle; daclrck follows it.
    always_comb begin
        slot_d = slot_q;
        lrck_d = lrck_q;
        if (fall) begin
            if (wrap) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + SLOT_ONE;
            end
            lrck_d = (slot_d >= SLOT_RIGHT);
        end
    end

    // Frame load and MSB-first shift-out. The shifter holds {L, R}; after
    // 2*SW-1 shifts its MSB is R[0], so the wrap toggle emits the previous
    // frame's R[0] in slot 0 while reloading the shifter with the new frame.
    always_comb begin
        shift_d   = shift_q;
        dat_d     = dat_q;
        frame_l_d = frame_l_q;
        frame_r_d = frame_r_q;
        if (fall) begin
            dat_d   = shift_q[FRAME_W-1];
            shift_d = {shift_q[FRAME_W-2:0], 1'b0};
        end
        if (wrap) begin
            if (mute) begin
                frame_l_d = '0;
                frame_r_d = '0;
            end else if (full_q) begin
                frame_l_d = left_align(hold_sin_q);
                frame_r_d = left_align(hold_cos_q);
            end
            // With nothing pending and no mute the previous frame repeats.
            shift_d = {frame_l_d, frame_r_d};
        end
    end

    // Holding register: a load consumes the pending pair, while a new pair
    // arriving on the same clk is still captured and left pending.
    always_comb begin
        hold_sin_d = hold_sin_q;
        hold_cos_d = hold_cos_q;
        full_d     = full_q;
        if (wrap) begin
            full_d = 1'b0;
        end
        if (in_valid) begin
            hold_sin_d = $signed(fsin_i);
            hold_cos_d = $signed(fcos_i);
            full_d     = 1'b1;
        end
    end

    // One-clk status pulses, registered so they line up with the load.
    always_comb begin
        req_d   = wrap;
        under_d = wrap & ~full_q;
        over_d  = in_valid & full_q & ~wrap;
    end

    // State registers; everything clears asynchronously so the outputs drop
    // to zero immediately and no partial frame survives a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            bclk_q     <= 1'b0;
            slot_q     <= '0;
            lrck_q     <= 1'b0;
            shift_q    <= '0;
            dat_q      <= 1'b0;
            frame_l_q  <= '0;
            frame_r_q  <= '0;
            hold_sin_q <= '0;
            hold_cos_q <= '0;
            full_q     <= 1'b0;
            req_q      <= 1'b0;
            under_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            bclk_q     <= bclk_d;
            slot_q     <= slot_d;
            lrck_q     <= lrck_d;
            shift_q    <= shift_d;
            dat_q      <= dat_d;
            frame_l_q  <= frame_l_d;
            frame_r_q  <= frame_r_d;
            hold_sin_q <= hold_sin_d;
            hold_cos_q <= hold_cos_d;
            full_q     <= full_d;
            req_q      <= req_d;
            under_q    <= under_d;
            over_q     <= over_d;
        end
    end

    assign bclk       = bclk_q;
    assign daclrck    = lrck_q;
    assign dacdat     = dat_q;
    assign sample_req = req_q;
    assign underrun   = under_q;
    assign overrun    = over_q;

endmodule

// File: tb/tb_nco_i2s_dac_tx.sv
// Testbench for nco_i2s_dac_tx: table-driven frame scenarios, a mid-frame
// reset sequence and a randomized phase, all checked against a frame-level
// reference model derived from clk counts since reset release.
module tb_nco_i2s_dac_tx;

    localparam int MPR = 14;
    localparam int SW  = 16;
    localparam int H   = 2;
    localparam int P   = 2 * H;        // clk per slot
    localparam int FR  = 2 * SW * P;   // clk per frame
    localparam int NF  = 64;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [MPR-1:0] fsin_i, fcos_i;
    logic           in_valid, mute;
    logic           sample_req, bclk, daclrck, dacdat, underrun, overrun;

    always #5 clk = ~clk;

    nco_i2s_dac_tx #(.MPR(MPR), .SW(SW), .BCLK_HALF(H)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .fsin_i     (fsin_i),
        .fcos_i     (fcos_i),
        .in_valid   (in_valid),
        .mute       (mute),
        .sample_req (sample_req),
        .bclk       (bclk),
        .daclrck    (daclrck),
        .dacdat     (dacdat),
        .underrun   (underrun),
        .overrun    (overrun)
    );

    int cmp_cnt = 0;
    int mis_cnt = 0;

    // Reference model state: n = rising clk edges since reset release.
    int             n;
    logic           m_full;
    logic [MPR-1:0] m_hs, m_hc;
    logic           e_req, e_under, e_over;
    logic [SW-1:0]  mL [NF];
    logic [SW-1:0]  mR [NF];

    // Words reassembled from the serial stream, per frame index.
    logic [SW-1:0]  cap_l [NF];
    logic [SW-1:0]  cap_r [NF];
    logic           cap_u [NF];
    int             cap_o [NF];

    typedef struct {
        int             nwr;
        logic [MPR-1:0] s0, c0, s1, c1;
        logic           vld_ld;
        logic [MPR-1:0] sl, cl;
        logic           mt;
        logic [SW-1:0]  el, er;
        logic           eu;
        int             eo;
    } vec_t;

    vec_t vt [12];

    function automatic vec_t mk(input int nwr, input logic [MPR-1:0] s0, input logic [MPR-1:0] c0,
                                input logic [MPR-1:0] s1, input logic [MPR-1:0] c1,
                                input logic vld_ld, input logic [MPR-1:0] sl, input logic [MPR-1:0] cl,
                                input logic mt, input logic [SW-1:0] el, input logic [SW-1:0] er,
                                input logic eu, input int eo);
        vec_t v;
        v.nwr = nwr; v.s0 = s0; v.c0 = c0; v.s1 = s1; v.c1 = c1;
        v.vld_ld = vld_ld; v.sl = sl; v.cl = cl; v.mt = mt;
        v.el = el; v.er = er; v.eu = eu; v.eo = eo;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            mis_cnt++;
            $display("FAIL %s: got %0h, expected %0h (n=%0d)", nm, act, exp, n);
        end
    endtask

    task automatic model_reset();
        n = 0; m_full = 1'b0; m_hs = '0; m_hc = '0;
        e_req = 1'b0; e_under = 1'b0; e_over = 1'b0;
        for (int i = 0; i < NF; i++) begin
            mL[i] = '0; mR[i] = '0; cap_l[i] = '0; cap_r[i] = '0;
            cap_u[i] = 1'b0; cap_o[i] = 0;
        end
    endtask

    // Applies the rules for one rising clk edge, using the inputs present at it.
    task automatic model_step();
        logic load, full_b;
        int   f;
        n++;
        load    = (n % FR == 0);
        full_b  = m_full;
        e_req   = load;
        e_under = load && !full_b;
        e_over  = in_valid && full_b && !load;
        if (load) begin
            f = n / FR;
            if (mute) begin
                mL[f] = '0; mR[f] = '0;
            end else if (full_b) begin
                mL[f] = SW'(32'(m_hs) << (SW - MPR));
                mR[f] = SW'(32'(m_hc) << (SW - MPR));
            end else begin
                mL[f] = mL[f-1]; mR[f] = mR[f-1];
            end
            m_full = 1'b0;
        end
        if (in_valid) begin
            m_hs = fsin_i; m_hc = fcos_i; m_full = 1'b1;
        end
    endtask

    // Per-cycle comparison of every output plus reassembly of the stream.
    task automatic monitor();
        int   s, f;
        logic ed;
        s = (n / P) % (2 * SW);
        f = n / FR;
        if (s == 0)       ed = (f == 0) ? 1'b0 : mR[f-1][0];
        else if (s <= SW) ed = mL[f][SW-s];
        else              ed = mR[f][2*SW-s];
        check("bclk",       32'(bclk),       32'((n / H) % 2));
        check("daclrck",    32'(daclrck),    32'(s >= SW));
        check("dacdat",     32'(dacdat),     32'(ed));
        check("sample_req", 32'(sample_req), 32'(e_req));
        check("underrun",   32'(underrun),   32'(e_under));
        check("overrun",    32'(overrun),    32'(e_over));
        if (n % P == H) begin
            if (s == 0) begin
                if (f >= 1) cap_r[f-1][0] = dacdat;
            end else if (s <= SW) begin
                cap_l[f][SW-s] = dacdat;
            end else begin
                cap_r[f][2*SW-s] = dacdat;
            end
        end
        if (n % FR == 0) cap_u[f] = underrun;
        if (overrun) cap_o[(n + FR - 1) / FR]++;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
        if (reset_n) monitor();
    endtask

    task automatic wait_n(input int t);
        while (n < t) cyc();
    endtask

    task automatic apply(input vec_t v, input int k);
        int base;
        base = FR * (k - 1);
        if (v.nwr >= 1) begin
            wait_n(base + 8);
            in_valid = 1'b1; fsin_i = v.s0; fcos_i = v.c0;
            cyc();
            in_valid = 1'b0;
        end
        if (v.nwr >= 2) begin
            wait_n(base + 40);
            in_valid = 1'b1; fsin_i = v.s1; fcos_i = v.c1;
            cyc();
            in_valid = 1'b0;
        end
        if (v.mt) begin
            wait_n(base + 60);
            mute = 1'b1;
        end
        wait_n(base + FR - 1);
        if (v.vld_ld) begin
            in_valid = 1'b1; fsin_i = v.sl; fcos_i = v.cl;
        end
        cyc();
        in_valid = 1'b0;
        mute     = 1'b0;
    endtask

    initial begin
        int got;
        reset_n = 1'b0; in_valid = 1'b0; mute = 1'b0;
        fsin_i = '0; fcos_i = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_bclk",       32'(bclk),       32'd0);
        check("rst_daclrck",    32'(daclrck),    32'd0);
        check("rst_dacdat",     32'(dacdat),     32'd0);
        check("rst_sample_req", 32'(sample_req), 32'd0);
        check("rst_underrun",   32'(underrun),   32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        reset_n = 1'b1;

        //              nwr s0       c0       s1       c1       vld   sl       cl       mt    L          R          u     o
        vt[0]  = mk(0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 0);
        vt[1]  = mk(1, 14'h1FFF, 14'h2000, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h7FFC, 16'h8000, 1'b0, 0);
        vt[2]  = mk(2, 14'h3FFF, 14'h0001, 14'h0AAA, 14'h1555, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h2AA8, 16'h5554, 1'b0, 1);
        vt[3]  = mk(1, 14'h0100, 14'h0200, 14'h0000, 14'h0000, 1'b1, 14'h0300, 14'h0400, 1'b0, 16'h0400, 16'h0800, 1'b0, 0);
        vt[4]  = mk(0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h0C00, 16'h1000, 1'b0, 0);
        vt[5]  = mk(1, 14'h0123, 14'h3ABC, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h048C, 16'hEAF0, 1'b0, 0);
        vt[6]  = mk(0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h048C, 16'hEAF0, 1'b1, 0);
        vt[7]  = mk(0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b1, 16'h0000, 16'h0000, 1'b1, 0);
        vt[8]  = mk(1, 14'h1FFF, 14'h1FFF, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b1, 16'h0000, 16'h0000, 1'b0, 0);
        vt[9]  = mk(0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 0);
        vt[10] = mk(0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b1, 14'h0555, 14'h0666, 1'b0, 16'h0000, 16'h0000, 1'b1, 0);
        vt[11] = mk(0, 14'h0000, 14'h0000, 14'h0000, 14'h0000, 1'b0, 14'h0000, 14'h0000, 1'b0, 16'h1554, 16'h1998, 1'b0, 0);

        for (int i = 0; i < 12; i++) apply(vt[i], i + 1);

        // Frame 12's last bit (R[0]) arrives in slot 0 of frame 13.
        wait_n(13 * FR + 8);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("vec%0d_L", i), 32'(cap_l[i+1]), 32'(vt[i].el));
            check($sformatf("vec%0d_R", i), 32'(cap_r[i+1]), 32'(vt[i].er));
            check($sformatf("vec%0d_underrun", i), 32'(cap_u[i+1]), 32'(vt[i].eu));
            check($sformatf("vec%0d_overrun", i), 32'(cap_o[i+1]), 32'(vt[i].eo));
        end

        // Mid-frame reset at slot 20 of frame 13 (repeat of 16'h1554/16'h1998),
        // bclk high and R[12]=1 on dacdat, so every output is visibly high.
        wait_n(13 * FR + 82);
        check("pre_rst_bclk",    32'(bclk),    32'd1);
        check("pre_rst_daclrck", 32'(daclrck), 32'd1);
        check("pre_rst_dacdat",  32'(dacdat),  32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_bclk",    32'(bclk),       32'd0);
        check("async_rst_daclrck", 32'(daclrck),    32'd0);
        check("async_rst_dacdat",  32'(dacdat),     32'd0);
        check("async_rst_req",     32'(sample_req), 32'd0);
        check("async_rst_under",   32'(underrun),   32'd0);
        check("async_rst_over",    32'(overrun),    32'd0);
        repeat (3) cyc();
        reset_n = 1'b1;

        got = 0;
        for (int c = 1; c <= 300; c++) begin
            cyc();
            if (sample_req) begin
                got = c;
                break;
            end
        end
        check("first_req_after_reset", 32'(got), 32'(FR));

        // Randomized phase: sparse in_valid with random data, mute chosen per frame.
        for (int r = 0; r < 8 * FR; r++) begin
            if (n % FR == 64) mute = ($urandom_range(0, 2) == 0);
            in_valid = ($urandom_range(0, 9) == 0);
            fsin_i   = MPR'($urandom);
            fcos_i   = MPR'($urandom);
            cyc();
        end
        in_valid = 1'b0;
        mute     = 1'b0;
        repeat (FR + 8) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
